xor_keystream_descrambler_32: RTL and testbench

- 32-bit stream descrambler. It is the receive-side counterpart of the team's 32-bit bitwise XOR scrambling path.
- Each accepted input word is XORed with a 32-bit LFSR keystream word. The result goes into a one-entry registered output stage with valid/ready flow control.
- The keystream advances one step per accepted word. It is (re)seeded by a load strobe.
- It sits between the link receive buffer and downstream consumers.

---
 rtl/xor_keystream_descrambler_32.sv | 87 ++++++++
 tb/tb_xor_keystream_descrambler_32.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_keystream_descrambler_32.sv
// 32-bit XOR keystream descrambler: each accepted word is XORed with an LFSR
// keystream word and presented through a one-entry valid/ready output register.
module xor_keystream_descrambler_32 #(
  parameter int          DATA_W       = 32,
  parameter logic [31:0] DEFAULT_SEED = 32'hFFFF_FFFF,
  parameter int          CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_seed,
  input  logic [DATA_W-1:0] seed,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  word_count
);

  // One keystream step; taps 31/21/1/0 feed the new LSB.
  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] k);
    lfsr_step = {k[DATA_W-2:0], k[31] ^ k[21] ^ k[1] ^ k[0]};
  endfunction

  logic [DATA_W-1:0] key_r;
  logic [DATA_W-1:0] m_data_r;
  logic              m_valid_r;
  logic [CNT_W-1:0]  word_count_r;

  logic [DATA_W-1:0] key_nxt_s;
  logic [DATA_W-1:0] m_data_nxt_s;
  logic              m_valid_nxt_s;
  logic [CNT_W-1:0]  word_count_nxt_s;
  logic              s_ready_s;
  logic              accept_s;

  assign s_ready_s  = ~rst & ~load_seed & (~m_valid_r | m_ready);
  assign accept_s   = s_valid & s_ready_s;
  assign s_ready    = s_ready_s;
  assign m_valid    = m_valid_r;
  assign m_data     = m_data_r;
  assign word_count = word_count_r;

  // Next-state: seed load has priority, then accept, otherwise drain or hold.
  always_comb begin
    key_nxt_s        = key_r;
    m_data_nxt_s     = m_data_r;
    m_valid_nxt_s    = m_valid_r;
    word_count_nxt_s = word_count_r;
    if (load_seed) begin
      // A zero seed would lock the LFSR at zero, so it falls back to the default.
      key_nxt_s        = (seed == {DATA_W{1'b0}}) ? DEFAULT_SEED : seed;
      word_count_nxt_s = {CNT_W{1'b0}};
      if (m_ready) begin
        m_valid_nxt_s = 1'b0;
      end else begin
        m_valid_nxt_s = m_valid_r;
      end
    end else if (accept_s) begin
      m_data_nxt_s     = s_data ^ key_r;
      m_valid_nxt_s    = 1'b1;
      key_nxt_s        = lfsr_step(key_r);
      word_count_nxt_s = word_count_r + CNT_W'(1);
    end else if (m_ready) begin
      m_valid_nxt_s = 1'b0;
    end else begin
      m_valid_nxt_s = m_valid_r;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r        <= DEFAULT_SEED;
      m_data_r     <= {DATA_W{1'b0}};
      m_valid_r    <= 1'b0;
      word_count_r <= {CNT_W{1'b0}};
    end else begin
      key_r        <= key_nxt_s;
      m_data_r     <= m_data_nxt_s;
      m_valid_r    <= m_valid_nxt_s;
      word_count_r <= word_count_nxt_s;
    end
  end

endmodule

// File: tb/tb_xor_keystream_descrambler_32.sv
// Self-checking bench for xor_keystream_descrambler_32: directed scenarios plus
// a randomized round trip through a behavioural scrambler model.
module tb_xor_keystream_descrambler_32;

  logic        clk;
  logic        rst;
  logic        load_seed;
  logic [31:0] seed;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [15:0] word_count;

  int n_tests;
  int n_fail;

  localparam logic [31:0] TAP_MASK = 32'h8020_0003;
  localparam int          N_RT     = 1000;

  xor_keystream_descrambler_32 dut (
    .clk        (clk),
    .rst        (rst),
    .load_seed  (load_seed),
    .seed       (seed),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference keystream: shift left, new LSB is the parity of the tapped bits.
  function automatic logic [31:0] ks_next(input logic [31:0] k);
    ks_next = (k << 1) | {31'd0, ^(k & TAP_MASK)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_seed = 1'b0; seed = 32'd0;
    s_valid = 1'b1; s_data = 32'd0; m_ready = 1'b1;
    #2;
    n_tests++;
    if (m_valid !== 1'b0 || m_data !== 32'd0 || word_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: m_valid=%b m_data=%h word_count=%0d, want 0/0/0", m_valid, m_data, word_count);
    end
    n_tests++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_s_ready: got %b want 0", s_ready);
    end
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] din [3];
    logic [31:0] exp [3];
    din[0] = 32'h0000_FFFF; din[1] = 32'h0000_5A55; din[2] = 32'h0000_AAAA;
    exp[0] = 32'hFFFF_0000; exp[1] = 32'hFFFF_A5AB; exp[2] = 32'hFFFF_5557;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== exp[i-1]) begin
          n_fail++;
          $display("FAIL basic_word%0d: m_valid=%b m_data=%h want 1/%h", i-1, m_valid, m_data, exp[i-1]);
        end
      end
      s_valid = 1'b1;
      s_data  = din[i];
    end
    @(negedge clk);
    s_valid = 1'b0;
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== exp[2] || word_count !== 16'd3) begin
      n_fail++;
      $display("FAIL basic_word2: m_valid=%b m_data=%h count=%0d want 1/%h/3", m_valid, m_data, word_count, exp[2]);
    end
    @(negedge clk);
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h0000_FFFF;
    @(negedge clk);
    s_data = 32'h0000_5A55;
    #1;
    n_tests++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_s_ready: got %b want 0", s_ready);
    end
    @(negedge clk);
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 32'hFFFF_0000 || word_count !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_hold: m_valid=%b m_data=%h count=%0d want 1/ffff0000/1", m_valid, m_data, word_count);
    end
    m_ready = 1'b1;
    #1;
    n_tests++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_resume_ready: got %b want 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 32'hFFFF_A5AB) begin
      n_fail++;
      $display("FAIL bp_resume: m_valid=%b m_data=%h want 1/ffffa5ab", m_valid, m_data);
    end
    @(negedge clk);
  endtask

  task automatic test_seed_load();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h0BAD_F00D;
    @(negedge clk);
    load_seed = 1'b1; seed = 32'h1234_5678; m_ready = 1'b1;
    #1;
    n_tests++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_s_ready: got %b want 0", s_ready);
    end
    @(negedge clk);
    load_seed = 1'b0;
    n_tests++;
    if (m_valid !== 1'b0 || word_count !== 16'd0) begin
      n_fail++;
      $display("FAIL seed_load: m_valid=%b count=%0d want 0/0", m_valid, word_count);
    end
    s_data = 32'h1234_5678;
    @(negedge clk);
    s_valid = 1'b0;
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 32'h0000_0000 || word_count !== 16'd1) begin
      n_fail++;
      $display("FAIL seed_word: m_valid=%b m_data=%h count=%0d want 1/00000000/1", m_valid, m_data, word_count);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_seed();
    load_seed = 1'b1; seed = 32'd0;
    @(negedge clk);
    load_seed = 1'b0;
    s_valid = 1'b1; s_data = 32'd0;
    @(negedge clk);
    s_valid = 1'b0;
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL zero_seed: m_valid=%b m_data=%h want 1/ffffffff", m_valid, m_data);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h5555_AAAA;
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (m_valid !== 1'b0 || word_count !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: m_valid=%b count=%0d want 0/0", m_valid, word_count);
    end
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b1; s_data = 32'h0000_FFFF; m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 32'hFFFF_0000) begin
      n_fail++;
      $display("FAIL async_reset_restart: m_valid=%b m_data=%h want 1/ffff0000", m_valid, m_data);
    end
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    logic [31:0] plain [N_RT];
    logic [31:0] scr   [N_RT];
    logic [31:0] k;
    logic [31:0] rs;
    int tx, rx, cycles, bad;
    rs = $urandom;
    k  = (rs == 32'd0) ? 32'hFFFF_FFFF : rs;
    for (int i = 0; i < N_RT; i++) begin
      plain[i] = $urandom;
      scr[i]   = plain[i] ^ k;
      k        = ks_next(k);
    end
    @(negedge clk);
    load_seed = 1'b1; seed = rs; m_ready = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    load_seed = 1'b0;
    tx = 0; rx = 0; cycles = 0; bad = 0;
    while (rx < N_RT && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      s_valid = (tx < N_RT) && ($urandom_range(0, 3) != 0);
      s_data  = (tx < N_RT) ? scr[tx] : $urandom;
      m_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (m_valid && m_ready) begin
        n_tests++;
        if (m_data !== plain[rx]) begin
          n_fail++;
          bad++;
          if (bad <= 10) $display("FAIL round_trip_word%0d: got %h want %h", rx, m_data, plain[rx]);
        end
        rx++;
      end
      if (s_valid && s_ready) tx++;
    end
    n_tests++;
    if (rx < N_RT) begin
      n_fail++;
      $display("FAIL round_trip_timeout: received %0d want %0d", rx, N_RT);
    end
    @(negedge clk);
    s_valid = 1'b0;
    n_tests++;
    if (word_count !== 16'(N_RT) || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL round_trip_end: count=%0d m_valid=%b want %0d/0", word_count, m_valid, N_RT);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_seed_load();
    test_zero_seed();
    test_async_reset();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
